// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the IF/MA memory port arbiter
package mem_arb_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  // MA-side opcode encodings shared with the memory-access stage glue
  localparam logic [3:0] LOAD  = 4'b1100;
  localparam logic [3:0] STORE = 4'b1110;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RETURN
  } arb_state_t;

  typedef enum logic {
    OWN_IF,
    OWN_MA
  } owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter between IF and MA with MA priority
// and an IF anti-starvation limit; sequences read latency and returns registered read data.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              ma_req,
  input  logic              ma_we,
  input  logic [ADDR_W-1:0] ma_addr,
  input  logic [DATA_W-1:0] ma_wdata,
  output logic [DATA_W-1:0] ma_rdata,
  output logic              ma_valid,
  output logic              ma_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [2:0] LAT_INIT   = 3'(MEM_LATENCY - 1);
  localparam logic [3:0] STREAK_MAX = 4'(STARVE_LIMIT);

  arb_state_t  state, state_nxt;
  logic [2:0]  lat_cnt, lat_cnt_nxt;
  owner_t      owner;
  logic [3:0]  streak;
  logic        grant_if, grant_ma;
  logic        issue_read;
  logic        capture_if, capture_ma;

  assign issue_read = grant_if | (grant_ma & ~ma_we);
  assign capture_if = (state == RETURN) && (owner == OWN_IF);
  assign capture_ma = (state == RETURN) && (owner == OWN_MA);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      lat_cnt <= 3'd0;
      owner   <= OWN_MA;
      streak  <= 4'd0;
    end else begin
      state   <= state_nxt;
      lat_cnt <= lat_cnt_nxt;
      if (issue_read)
        owner <= grant_if ? OWN_IF : OWN_MA;
      // streak only counts MA wins that actually kept a pending IF waiting
      if (!if_req || grant_if)
        streak <= 4'd0;
      else if (grant_ma && streak != STREAK_MAX)
        streak <= streak + 4'd1;
    end
  end

  always_comb begin
    state_nxt   = state;
    lat_cnt_nxt = lat_cnt;
    unique case (state)
      IDLE: begin
        if (issue_read) begin
          lat_cnt_nxt = LAT_INIT;
          state_nxt   = (LAT_INIT == 3'd0) ? RETURN : WAIT;
        end
      end
      WAIT: begin
        lat_cnt_nxt = lat_cnt - 3'd1;
        if (lat_cnt == 3'd1)
          state_nxt = RETURN;
      end
      RETURN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    grant_if  = 1'b0;
    grant_ma  = 1'b0;
    if (!rst && state == IDLE) begin
      if (if_req && (!ma_req || streak == STREAK_MAX))
        grant_if = 1'b1;
      else if (ma_req)
        grant_ma = 1'b1;
    end
    mem_en    = grant_if | grant_ma;
    mem_we    = grant_ma & ma_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant_if) begin
      mem_addr = if_addr;
    end else if (grant_ma) begin
      mem_addr  = ma_addr;
      mem_wdata = ma_wdata;
    end
    if_stall = if_req & ~grant_if;
    ma_stall = ma_req & ~grant_ma;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_rdata <= '0;
      ma_rdata <= '0;
      if_valid <= 1'b0;
      ma_valid <= 1'b0;
    end else begin
      if_valid <= capture_if;
      ma_valid <= capture_ma;
      if (capture_if)
        if_rdata <= mem_rdata;
      if (capture_ma)
        ma_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench: three arbiter configurations driven in parallel
// against a cycle-numbered behavioural model, plus directed literal expectations.
module tb_mem_port_arbiter;

  localparam int L_T [3] = '{1, 1, 3};
  localparam int S_T [3] = '{4, 2, 4};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0, ma_req = 1'b0, ma_we = 1'b0;
  logic [15:0] if_addr = 16'h0, ma_addr = 16'h0, ma_wdata = 16'h0, mem_rdata = 16'h0;

  logic        if_valid [3], if_stall [3], ma_valid [3], ma_stall [3], mem_en [3], mem_we [3];
  logic [15:0] if_rdata [3], ma_rdata [3], mem_addr [3], mem_wdata [3];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // model state, one slot per DUT instance
  int          free_c [3];
  int          cap_c  [3];
  int          vcyc   [3];
  logic        own_if [3];
  logic        vown_if[3];
  logic [15:0] rd_if  [3];
  logic [15:0] rd_ma  [3];
  int          streak [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(4)) u0 (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata[0]),
    .if_valid(if_valid[0]), .if_stall(if_stall[0]), .ma_req(ma_req), .ma_we(ma_we),
    .ma_addr(ma_addr), .ma_wdata(ma_wdata), .ma_rdata(ma_rdata[0]), .ma_valid(ma_valid[0]),
    .ma_stall(ma_stall[0]), .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata));

  mem_port_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(2)) u1 (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata[1]),
    .if_valid(if_valid[1]), .if_stall(if_stall[1]), .ma_req(ma_req), .ma_we(ma_we),
    .ma_addr(ma_addr), .ma_wdata(ma_wdata), .ma_rdata(ma_rdata[1]), .ma_valid(ma_valid[1]),
    .ma_stall(ma_stall[1]), .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata));

  mem_port_arbiter #(.MEM_LATENCY(3), .STARVE_LIMIT(4)) u2 (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata[2]),
    .if_valid(if_valid[2]), .if_stall(if_stall[2]), .ma_req(ma_req), .ma_we(ma_we),
    .ma_addr(ma_addr), .ma_wdata(ma_wdata), .ma_rdata(ma_rdata[2]), .ma_valid(ma_valid[2]),
    .ma_stall(ma_stall[2]), .mem_en(mem_en[2]), .mem_we(mem_we[2]), .mem_addr(mem_addr[2]),
    .mem_wdata(mem_wdata[2]), .mem_rdata(mem_rdata));

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%b required=%b", nm, cyc, act, exp);
    end
  endtask

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
    end
  endtask

  // Read issued at cycle n occupies the port until n+L, is captured at n+L and
  // signalled at n+L+1; the port accepts a new grant from n+L+1 on.
  task automatic model_step(input int k);
    logic        idle, gi, gm;
    logic [15:0] e_addr, e_wd;
    if (rst) begin
      free_c[k] = cyc;
      cap_c[k]  = -1;
      vcyc[k]   = -1;
      rd_if[k]  = 16'h0;
      rd_ma[k]  = 16'h0;
      streak[k] = 0;
    end
    idle   = !rst && (cyc >= free_c[k]);
    gi     = idle && if_req && (!ma_req || streak[k] == S_T[k]);
    gm     = idle && ma_req && !gi;
    e_addr = gi ? if_addr : (gm ? ma_addr : 16'h0);
    e_wd   = gm ? ma_wdata : 16'h0;
    chk1($sformatf("u%0d.mem_en", k), mem_en[k], gi | gm);
    chk1($sformatf("u%0d.mem_we", k), mem_we[k], gm & ma_we);
    chk16($sformatf("u%0d.mem_addr", k), mem_addr[k], e_addr);
    chk16($sformatf("u%0d.mem_wdata", k), mem_wdata[k], e_wd);
    chk1($sformatf("u%0d.if_stall", k), if_stall[k], if_req & !gi);
    chk1($sformatf("u%0d.ma_stall", k), ma_stall[k], ma_req & !gm);
    chk1($sformatf("u%0d.if_valid", k), if_valid[k], (vcyc[k] == cyc) && vown_if[k]);
    chk1($sformatf("u%0d.ma_valid", k), ma_valid[k], (vcyc[k] == cyc) && !vown_if[k]);
    chk16($sformatf("u%0d.if_rdata", k), if_rdata[k], rd_if[k]);
    chk16($sformatf("u%0d.ma_rdata", k), ma_rdata[k], rd_ma[k]);
    if (!rst) begin
      if (cyc == cap_c[k]) begin
        if (own_if[k]) rd_if[k] = mem_rdata;
        else           rd_ma[k] = mem_rdata;
        vcyc[k]    = cyc + 1;
        vown_if[k] = own_if[k];
      end
      if (gi || (gm && !ma_we)) begin
        own_if[k] = gi;
        cap_c[k]  = cyc + L_T[k];
        free_c[k] = cyc + L_T[k] + 1;
      end
      if (!if_req || gi)
        streak[k] = 0;
      else if (gm && streak[k] < S_T[k])
        streak[k] = streak[k] + 1;
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      free_c[k] = 0; cap_c[k] = -1; vcyc[k] = -1; own_if[k] = 1'b0; vown_if[k] = 1'b0;
      rd_if[k] = 16'h0; rd_ma[k] = 16'h0; streak[k] = 0;
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) model_step(k);
  end

  task automatic set(input logic ir, input logic [15:0] ia, input logic mr, input logic mw,
                     input logic [15:0] ma, input logic [15:0] md, input logic [15:0] mrd);
    @(posedge clk);
    #1;
    if_req = ir; if_addr = ia; ma_req = mr; ma_we = mw; ma_addr = ma; ma_wdata = md;
    mem_rdata = mrd;
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) set(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
  endtask

  initial begin
    // reset state, including a request presented while reset is held
    idle_cycles(2);
    chk1("rst.if_valid", if_valid[0], 1'b0);
    chk16("rst.if_rdata", if_rdata[0], 16'h0);
    set(1'b0, 16'h0, 1'b1, 1'b1, 16'h0010, 16'h1111, 16'h0);
    chk1("rst.mem_en_blocked", mem_en[0], 1'b0);
    chk1("rst.ma_stall", ma_stall[0], 1'b1);
    idle_cycles(1);
    #2 rst = 1'b0;
    idle_cycles(2);

    // store only
    set(1'b0, 16'h0, 1'b1, 1'b1, 16'h0010, 16'hBEEF, 16'h0);
    chk1("st.mem_en", mem_en[0], 1'b1);
    chk1("st.mem_we", mem_we[0], 1'b1);
    chk16("st.mem_addr", mem_addr[0], 16'h0010);
    chk16("st.mem_wdata", mem_wdata[0], 16'hBEEF);
    chk1("st.ma_stall", ma_stall[0], 1'b0);
    idle_cycles(1);
    chk1("st.no_valid1", ma_valid[0], 1'b0);
    chk1("st.mem_en_off", mem_en[0], 1'b0);
    idle_cycles(1);
    chk1("st.no_valid2", ma_valid[0], 1'b0);
    idle_cycles(4);

    // IF read, latency 1
    set(1'b1, 16'h0004, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
    chk1("ifr.if_stall", if_stall[0], 1'b0);
    chk16("ifr.mem_addr", mem_addr[0], 16'h0004);
    set(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h1234);
    chk1("ifr.mem_en_t1", mem_en[0], 1'b0);
    chk1("ifr.early_valid", if_valid[0], 1'b0);
    idle_cycles(1);
    chk1("ifr.if_valid", if_valid[0], 1'b1);
    chk16("ifr.if_rdata", if_rdata[0], 16'h1234);
    idle_cycles(6);

    // contention: MA load wins, IF follows once the port frees
    set(1'b1, 16'h0008, 1'b1, 1'b0, 16'h0020, 16'h0, 16'h0);
    chk16("con.mem_addr_t0", mem_addr[0], 16'h0020);
    chk1("con.if_stall_t0", if_stall[0], 1'b1);
    chk1("con.ma_stall_t0", ma_stall[0], 1'b0);
    set(1'b1, 16'h0008, 1'b0, 1'b0, 16'h0, 16'h0, 16'h5555);
    chk1("con.if_stall_t1", if_stall[0], 1'b1);
    set(1'b1, 16'h0008, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
    chk16("con.mem_addr_t2", mem_addr[0], 16'h0008);
    chk1("con.if_stall_t2", if_stall[0], 1'b0);
    chk1("con.ma_valid", ma_valid[0], 1'b1);
    chk16("con.ma_rdata", ma_rdata[0], 16'h5555);
    set(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h6666);
    idle_cycles(1);
    chk1("con.if_valid", if_valid[0], 1'b1);
    chk16("con.if_rdata", if_rdata[0], 16'h6666);
    idle_cycles(8);

    // starvation: limit 2 forces IF on the third contended cycle
    set(1'b1, 16'h0040, 1'b1, 1'b1, 16'h0100, 16'h0001, 16'h0);
    chk16("stv.mem_addr_t0", mem_addr[1], 16'h0100);
    chk1("stv.if_stall_t0", if_stall[1], 1'b1);
    set(1'b1, 16'h0040, 1'b1, 1'b1, 16'h0101, 16'h0002, 16'h0);
    chk16("stv.mem_addr_t1", mem_addr[1], 16'h0101);
    set(1'b1, 16'h0040, 1'b1, 1'b1, 16'h0102, 16'h0003, 16'h0);
    chk16("stv.mem_addr_t2", mem_addr[1], 16'h0040);
    chk1("stv.mem_we_t2", mem_we[1], 1'b0);
    chk1("stv.ma_stall_t2", ma_stall[1], 1'b1);
    chk1("stv.if_stall_t2", if_stall[1], 1'b0);
    chk16("stv.lim4_still_ma", mem_addr[0], 16'h0102);
    set(1'b0, 16'h0, 1'b1, 1'b1, 16'h0102, 16'h0003, 16'hA5A5);
    chk1("stv.ma_stall_t3", ma_stall[1], 1'b1);
    set(1'b0, 16'h0, 1'b1, 1'b1, 16'h0102, 16'h0003, 16'h0);
    chk1("stv.if_valid", if_valid[1], 1'b1);
    chk16("stv.if_rdata", if_rdata[1], 16'hA5A5);
    chk16("stv.ma_regrant", mem_addr[1], 16'h0102);
    idle_cycles(8);

    // latency 3 sweep
    set(1'b0, 16'h0, 1'b1, 1'b0, 16'h0030, 16'h0, 16'h0);
    chk1("lat.mem_en_t0", mem_en[2], 1'b1);
    for (int i = 1; i <= 3; i++) begin
      set(1'b1, 16'h0050, 1'b1, 1'b1, 16'h0031, 16'h0, (i == 3) ? 16'h7777 : 16'h0);
      chk1($sformatf("lat.if_stall_t%0d", i), if_stall[2], 1'b1);
      chk1($sformatf("lat.ma_stall_t%0d", i), ma_stall[2], 1'b1);
      chk1($sformatf("lat.ma_valid_t%0d", i), ma_valid[2], 1'b0);
    end
    set(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
    chk1("lat.ma_valid_t4", ma_valid[2], 1'b1);
    chk16("lat.ma_rdata", ma_rdata[2], 16'h7777);
    idle_cycles(8);

    // asynchronous reset in the middle of an IF read
    set(1'b1, 16'h0060, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
    @(posedge clk);
    #1;
    if_req = 1'b0; mem_rdata = 16'h9999;
    #2 rst = 1'b1;
    @(negedge clk);
    chk1("mrst.mem_en", mem_en[0], 1'b0);
    chk16("mrst.if_rdata_cleared", if_rdata[0], 16'h0);
    #2 rst = 1'b0;
    idle_cycles(1);
    chk1("mrst.no_valid1", if_valid[0], 1'b0);
    chk16("mrst.if_rdata", if_rdata[0], 16'h0);
    idle_cycles(1);
    chk1("mrst.no_valid2", if_valid[0], 1'b0);
    set(1'b1, 16'h0070, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
    chk1("mrst.reissue", mem_en[0], 1'b1);
    chk16("mrst.reissue_addr", mem_addr[0], 16'h0070);
    set(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 16'hC3C3);
    idle_cycles(1);
    chk1("mrst.if_valid", if_valid[0], 1'b1);
    chk16("mrst.if_rdata_new", if_rdata[0], 16'hC3C3);
    idle_cycles(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
